// File: rtl/bram_word_pkg.sv
// ---------------------------------------------------------------------------
// bram_word_pkg
// Purpose : shared word-geometry constants for the byte-enabled word memory
//           and the SDRAM cache that instantiates it (tag/flags array and
//           one instance per cache-line column).
// Contents: DATA_WIDTH, BYTES_PER_WORD, BYTE_WIDTH and a byte-merge helper
//           used to build the write-through read word.
// ---------------------------------------------------------------------------
package bram_word_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_WIDTH     = 8;

  // Merge new_word into old_word on the byte lanes selected by byte_en.
  // Lanes whose enable is not a clean 1 keep the old byte.
  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0]     old_word,
    input logic [DATA_WIDTH-1:0]     new_word,
    input logic [BYTES_PER_WORD-1:0] byte_en
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int n = 0; n < BYTES_PER_WORD; n++) begin
      if (byte_en[n]) begin
        merged[n*BYTE_WIDTH +: BYTE_WIDTH] = new_word[n*BYTE_WIDTH +: BYTE_WIDTH];
      end else begin
        merged[n*BYTE_WIDTH +: BYTE_WIDTH] = old_word[n*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/bram_word.sv
// ---------------------------------------------------------------------------
// bram_word
// Purpose : single-port, byte-write-enabled 32-bit word memory with a
//           registered (1-cycle) synchronous read, written so that FPGA
//           synthesis infers one byte-enabled block RAM.
// Ports   :
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset (clears data_out only,
//                     suppresses that cycle's write, leaves contents intact)
//   write_enable in   [3:0] byte-lane write enables, bit n -> data_in[8n+7:8n]
//   address      in   [AddressBitWidth-1:0] word index (all values valid)
//   data_in      in   [31:0] write data
//   data_out     out  [31:0] registered read data
// Config  : macro BRAM_WRITE_FIRST_EN selects write-first behaviour on a
//           same-address read-during-write (data_out gets the merged word).
//           Undefined (default): read-first, data_out gets the old word.
// ---------------------------------------------------------------------------
module bram_word
  import bram_word_pkg::*;
#(
  parameter int AddressBitWidth = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BYTES_PER_WORD-1:0]  write_enable,
  input  logic [AddressBitWidth-1:0] address,
  input  logic [DATA_WIDTH-1:0]      data_in,
  output logic [DATA_WIDTH-1:0]      data_out
);

  localparam int DEPTH = 2 ** AddressBitWidth;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_out;

  // Power-up contents are zero so cache valid/dirty flags read 0; this
  // becomes the block RAM initialisation image, not reset logic.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      r_mem[i] = {DATA_WIDTH{1'b0}};
    end
  end

`ifdef BRAM_WRITE_FIRST_EN
  logic [DATA_WIDTH-1:0] w_read_word;

  // Write-through read word: written lanes from data_in, others from array.
  always_comb begin
    w_read_word = byte_merge(r_mem[address], data_in, write_enable);
  end
`endif

  // Byte-lane writes and registered read. Reset only touches the output
  // register and blocks the write; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out <= {DATA_WIDTH{1'b0}};
    end else begin
      for (int n = 0; n < BYTES_PER_WORD; n++) begin
        // An X enable is not taken as true, so unselected bytes stay intact.
        if (write_enable[n]) begin
          r_mem[address][n*BYTE_WIDTH +: BYTE_WIDTH] <= data_in[n*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
`ifdef BRAM_WRITE_FIRST_EN
      r_data_out <= w_read_word;
`else
      // Non-blocking read of the array yields the pre-write word (read-first).
      r_data_out <= r_mem[address];
`endif
    end
  end

  assign data_out = r_data_out;

endmodule

// File: tb/tb_bram_word.sv
// ---------------------------------------------------------------------------
// tb_bram_word
// Self-checking bench for bram_word (AddressBitWidth = 6). A plain array
// model tracks memory contents and the expected registered output; directed
// sequences cover reset, full/partial writes, read-during-write, reset write
// suppression and an address sweep, followed by random traffic.
// Honors BRAM_WRITE_FIRST_EN for the expected read-during-write result.
// ---------------------------------------------------------------------------
module tb_bram_word;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk;
  logic          rst;
  logic [3:0]    write_enable;
  logic [AW-1:0] address;
  logic [31:0]   data_in;
  logic [31:0]   data_out;

  int unsigned total;
  int unsigned bad;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_out;

  bram_word #(.AddressBitWidth(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
    end
  endtask

  // One access cycle: apply inputs at negedge, update the model at the edge,
  // check data_out shortly after the edge.
  task automatic step(input logic r, input logic [3:0] we, input logic [AW-1:0] a,
                      input logic [31:0] d, input string tag);
    logic [31:0] old_word;
    logic [31:0] new_word;
    @(negedge clk);
    rst = r;
    write_enable = we;
    address = a;
    data_in = d;
    @(posedge clk);
    if (r) begin
      exp_out = 32'h0000_0000;
    end else begin
      old_word = model_mem[a];
      new_word = old_word;
      for (int b = 0; b < 4; b++) begin
        if (we[b]) new_word[b*8 +: 8] = d[b*8 +: 8];
      end
      model_mem[a] = new_word;
`ifdef BRAM_WRITE_FIRST_EN
      exp_out = new_word;
`else
      exp_out = old_word;
`endif
    end
    #1;
    check_val(tag, data_out, exp_out);
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0000_0000;
    rst = 1'b1;
    write_enable = 4'b0000;
    address = '0;
    data_in = 32'h0000_0000;

    // Reset for two cycles, then initial contents.
    step(1'b1, 4'b0000, 6'd0, 32'h0, "rst_cyc0");
    step(1'b1, 4'b0000, 6'd0, 32'h0, "rst_cyc1");
    check_val("rst_const", data_out, 32'h0000_0000);
    step(1'b0, 4'b0000, 6'd0,  32'h0, "init_a0");
    step(1'b0, 4'b0000, 6'd1,  32'h0, "init_a1");
    step(1'b0, 4'b0000, 6'd63, 32'h0, "init_a63");
    check_val("init_a63_const", data_out, 32'h0000_0000);

    // Full-word write then readback.
    step(1'b0, 4'b1111, 6'd5, 32'hDEADBEEF, "wr_full");
    step(1'b0, 4'b0000, 6'd5, 32'h0, "rd_full");
    check_val("rd_full_const", data_out, 32'hDEADBEEF);

    // Byte merge and null write.
    step(1'b0, 4'b0101, 6'd5, 32'h11223344, "wr_merge");
    step(1'b0, 4'b0000, 6'd5, 32'h0, "rd_merge");
    check_val("rd_merge_const", data_out, 32'hDE22BE44);
    step(1'b0, 4'b0000, 6'd5, 32'hFFFFFFFF, "wr_none");
    step(1'b0, 4'b0000, 6'd5, 32'h0, "rd_none");
    check_val("rd_none_const", data_out, 32'hDE22BE44);

    // Read-during-write on address 7.
    step(1'b0, 4'b1111, 6'd7, 32'hAAAAAAAA, "rdw_setup");
    step(1'b0, 4'b1111, 6'd7, 32'h55555555, "rdw_edge");
`ifdef BRAM_WRITE_FIRST_EN
    check_val("rdw_edge_const", data_out, 32'h55555555);
`else
    check_val("rdw_edge_const", data_out, 32'hAAAAAAAA);
`endif
    step(1'b0, 4'b0000, 6'd7, 32'h0, "rdw_next");
    check_val("rdw_next_const", data_out, 32'h55555555);

    // Reset suppresses the write.
    step(1'b1, 4'b1111, 6'd9, 32'h12345678, "rst_wr");
    check_val("rst_wr_const", data_out, 32'h0000_0000);
    step(1'b0, 4'b0000, 6'd9, 32'h0, "rst_wr_rd");
    check_val("rst_wr_rd_const", data_out, 32'h0000_0000);

    // Address sweep: write all, read back in reverse.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 4'b1111, i[AW-1:0], i * 32'h01010101, "sweep_wr");
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      step(1'b0, 4'b0000, i[AW-1:0], 32'h0, "sweep_rd");
      check_val("sweep_rd_const", data_out, i * 32'h01010101);
    end
    // 63 then 0.
    step(1'b0, 4'b0000, 6'd63, 32'h0, "wrap_63");
    check_val("wrap_63_const", data_out, 32'h3F3F3F3F);
    step(1'b0, 4'b0000, 6'd0, 32'h0, "wrap_0");
    check_val("wrap_0_const", data_out, 32'h00000000);

    // Random traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)),
           6'($urandom_range(0, DEPTH - 1)),
           32'($urandom),
           "random");
    end

    // Final readback of the whole array against the model.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 4'b0000, i[AW-1:0], 32'h0, "final_rd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
